// File: rtl/leb128_encoder.sv
// LEB128 encoder: turns a 64-bit (or sign/zero-extended 32-bit) value into a
// minimal-length stream of signed or unsigned LEB128 bytes over a stb/ack handshake.
module leb128_encoder (
  input  logic        clk,
  input  logic        reset,
  input  logic [63:0] input_a,
  input  logic        input_signed,
  input  logic        input_is32,
  input  logic        input_a_stb,
  output logic        input_a_ack,
  output logic [7:0]  output_z,
  output logic        output_z_last,
  output logic [3:0]  output_len,
  output logic        output_z_stb,
  input  logic        output_z_ack
);

  typedef enum logic [1:0] {
    GET_A,
    ENCODE,
    PUT_Z
  } state_t;

  state_t      state, state_nxt;
  logic [63:0] shreg, shreg_nxt;
  logic        sign_q, sign_nxt;
  logic [3:0]  count, count_nxt;
  logic        ack_nxt;
  logic [7:0]  z_nxt;
  logic        last_nxt;
  logic [3:0]  len_nxt;
  logic        stb_nxt;

  logic [63:0] a_ext;
  logic        term;

  always_comb begin
    if (input_is32) begin
      a_ext = input_signed ? {{32{input_a[31]}}, input_a[31:0]} : {32'd0, input_a[31:0]};
    end else begin
      a_ext = input_a;
    end
  end

  // Signed streams stop once the remaining bits are pure sign extension of bit 6.
  always_comb begin
    if (sign_q) begin
      term = ((shreg[63:7] == 57'd0) && !shreg[6]) ||
             ((&shreg[63:7]) && shreg[6]);
    end else begin
      term = (shreg[63:7] == 57'd0);
    end
  end

  always_comb begin
    // NOTE: every next-value gets a hold default first, so no path through the case infers a latch.
    state_nxt = state;
    shreg_nxt = shreg;
    sign_nxt  = sign_q;
    count_nxt = count;
    ack_nxt   = input_a_ack;
    z_nxt     = output_z;
    last_nxt  = output_z_last;
    len_nxt   = output_len;
    stb_nxt   = output_z_stb;

    case (state)
      GET_A: begin
        ack_nxt = 1'b1;
        if (input_a_stb && input_a_ack) begin
          shreg_nxt = a_ext;
          sign_nxt  = input_signed;
          count_nxt = 4'd0;
          ack_nxt   = 1'b0;
          state_nxt = ENCODE;
        end
      end

      ENCODE: begin
        z_nxt     = {~term, shreg[6:0]};
        last_nxt  = term;
        len_nxt   = count + 4'd1;
        stb_nxt   = 1'b1;
        state_nxt = PUT_Z;
      end

      PUT_Z: begin
        if (output_z_stb && output_z_ack) begin
          stb_nxt = 1'b0;
          if (output_z_last) begin
            ack_nxt   = 1'b1;
            state_nxt = GET_A;
          end else begin
            shreg_nxt = sign_q ? {{7{shreg[63]}}, shreg[63:7]} : {7'd0, shreg[63:7]};
            count_nxt = count + 4'd1;
            state_nxt = ENCODE;
          end
        end
      end

      default: state_nxt = GET_A;
    endcase
  end

  // Reset drives every output low immediately, abandoning any encoding in flight.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state         <= GET_A;
      shreg         <= 64'd0;
      sign_q        <= 1'b0;
      count         <= 4'd0;
      input_a_ack   <= 1'b0;
      output_z      <= 8'd0;
      output_z_last <= 1'b0;
      output_len    <= 4'd0;
      output_z_stb  <= 1'b0;
    end else begin
      // NOTE: non-blocking assignments so all registers update from the same pre-edge values.
      state         <= state_nxt;
      shreg         <= shreg_nxt;
      sign_q        <= sign_nxt;
      count         <= count_nxt;
      input_a_ack   <= ack_nxt;
      output_z      <= z_nxt;
      output_z_last <= last_nxt;
      output_len    <= len_nxt;
      output_z_stb  <= stb_nxt;
    end
  end

endmodule

// File: doc/leb128_encoder.md
LEB128_ENCODER -- requirements
Module: leb128_encoder

Interface
REQ-001 The block SHALL have no parameters; the value width is fixed at 64 bits and the maximum encoded length at 10 bytes.
REQ-002 clk  in  1  sole clock; all state changes on posedge clk.
REQ-003 reset  in  1  asynchronous, active-high reset.
REQ-004 input_a  in  64  value to encode.
REQ-005 input_signed  in  1  1 = signed LEB128 (varintN), 0 = unsigned LEB128 (varuintN).
REQ-006 input_is32  in  1  1 = encode only input_a[31:0], sign- or zero-extended per input_signed; input_a[63:32] ignored.
REQ-007 input_a_stb  in  1  producer asserts when input_a, input_signed and input_is32 are valid.
REQ-008 input_a_ack  out  1  block ready to accept a value.
REQ-009 output_z  out  8  current encoded byte.
REQ-010 output_z_last  out  1  current byte is the final byte of the encoding.
REQ-011 output_len  out  4  1-based index of the current byte (1..10).
REQ-012 output_z_stb  out  1  output_z, output_z_last and output_len are valid.
REQ-013 output_z_ack  in  1  consumer accepts the current byte.

Function
REQ-014 The FSM SHALL have exactly three states: GET_A, ENCODE and PUT_Z.
REQ-015 GET_A: input_a_ack = 1; on a cycle with input_a_stb & input_a_ack, the block SHALL latch the extended 64-bit value into a shift register, latch input_signed, clear the byte count, drop input_a_ack and go to ENCODE.
REQ-016 ENCODE: the block SHALL form the byte as {continue, shreg[6:0]}, with output_len = count+1, assert output_z_stb and go to PUT_Z.
REQ-017 Unsigned termination SHALL be (shreg >> 7) == 0.
REQ-018 Signed termination SHALL be ((shreg >>> 7) == 0 && shreg[6] == 0) || ((shreg >>> 7) == all-ones && shreg[6] == 1).
REQ-019 continue SHALL be the inverse of termination, and output_z_last SHALL equal termination.
REQ-020 PUT_Z: output_z, output_z_last, output_len and output_z_stb SHALL be held stable until output_z_stb & output_z_ack; backpressure duration is unbounded.
REQ-021 On acceptance with last = 1, the block SHALL drop output_z_stb, return to GET_A and reassert input_a_ack on the following cycle.
REQ-022 On acceptance with last = 0, the block SHALL drop output_z_stb, shift shreg right by 7 (arithmetic if signed, logical if unsigned), increment count and go to ENCODE.
REQ-023 Latency SHALL be: input handshake at cycle N gives first byte stb at N+2; with ack always high, each subsequent byte follows 2 cycles after the previous acceptance.
REQ-024 The encoding SHALL be minimal-length; maximum length is 10 bytes for 64-bit values and 5 bytes for input_is32 values.
REQ-025 output_len SHALL never exceed 10, and no other length or range checking is required.
REQ-026 input_a_stb while not in GET_A SHALL be ignored (input_a_ack = 0).
REQ-027 output_z_ack while output_z_stb = 0 SHALL be ignored.

Reset
REQ-028 While reset is high, the outputs SHALL be: state = GET_A, input_a_ack = 0, output_z_stb = 0, output_z = 0, output_z_last = 0, output_len = 0, and shreg/count cleared.
REQ-029 The reset effect on all outputs SHALL be immediate (asynchronous), including mid-encoding; any partially emitted encoding SHALL be abandoned.
REQ-030 input_a_ack SHALL assert on the first posedge after reset deasserts.

Verification
REQ-031 Unsigned 64-bit 624485 -> bytes E5, 8E, 26; last only on 26; output_len 1, 2, 3.
REQ-032 Signed 64-bit -123456 -> C0, BB, 78; unsigned 0 -> single 00 with last = 1; signed -1 -> single 7F with last = 1.
REQ-033 Unsigned 64-bit 0xFFFF_FFFF_FFFF_FFFF -> nine FF bytes then 01; output_len = 10 on the last byte.
REQ-034 input_is32 signed with input_a = 0xDEAD_BEEF_8000_0000 -> 80, 80, 80, 80, 78 (5 bytes); input_is32 unsigned with 0xDEAD_BEEF_0000_0080 -> 80, 01.
REQ-035 Hold output_z_ack low 5 cycles on byte 2 of 624485 -> output_z remains 8E with stb high throughout; the sequence completes correctly after ack.
REQ-036 Assert reset between the 1st and 2nd byte of a 10-byte encoding -> output_z_stb falls in the same cycle without waiting for clk; after release, a new value 5 encodes as a single 05.
